// File: rtl/tmc_pkg.sv
// Shared definitions for the stepper-driver register sequencer: FSM states,
// datagram field positions and frame timing helper.
package tmc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP,
        ST_CAPTURE
    } seq_state_e;

    localparam int DGRAM_WRITE_BIT = 39;
    localparam int DGRAM_ADDR_HI   = 38;
    localparam int DGRAM_ADDR_LO   = 32;
    localparam int DGRAM_DATA_W    = 32;
    localparam int STATUS_W        = 8;

    // Enable must stay high three cycles longer than the datagram so the SPI master completes the frame.
    function automatic int FRAME_CYCLES(input int size);
        return size + 3;
    endfunction

endpackage

// File: rtl/tmc_reg_sequencer.sv
// Turns single register read/write requests into 40-bit stepper-driver datagrams
// for the SPI master; reads run as two identical frames because read data comes back one datagram late.
module tmc_reg_sequencer
    import tmc_pkg::*;
#(
    parameter int SIZE       = 40,
    parameter int CS_SIZE    = 1,
    parameter int GAP_CYCLES = 2
) (
    input  logic                internal_clk,
    input  logic                reset_n_in,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [6:0]          req_addr,
    input  logic [31:0]         req_data,
    input  logic [CS_SIZE-1:0]  req_cs,
    output logic                rsp_valid,
    output logic [STATUS_W-1:0] rsp_status,
    output logic [31:0]         rsp_data,
    output logic [SIZE-1:0]     spi_data_out,
    output logic                spi_send_enable,
    output logic [CS_SIZE-1:0]  spi_cs_select,
    input  logic [SIZE-1:0]     spi_data_in,
    output logic                busy
);

    localparam int CNT_W = $clog2(SIZE + 3 + GAP_CYCLES);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES(SIZE) - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    seq_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic [SIZE-1:0]       dgram_q, dgram_d;
    logic [CS_SIZE-1:0]    cs_q, cs_d;
    logic                  en_q, en_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [STATUS_W-1:0]   rsp_status_q, rsp_status_d;
    logic [31:0]           rsp_data_q, rsp_data_d;

    // Ready is held off for the response cycle so a new request lands one cycle after rsp_valid.
    assign req_ready       = (state_q == ST_IDLE) && !rsp_valid_q;
    assign busy            = !req_ready;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_status      = rsp_status_q;
    assign rsp_data        = rsp_data_q;
    assign spi_data_out    = dgram_q;
    assign spi_cs_select   = cs_q;
    assign spi_send_enable = en_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        phase_d      = phase_q;
        dgram_d      = dgram_q;
        cs_d         = cs_q;
        rsp_valid_d  = 1'b0;
        rsp_status_d = rsp_status_q;
        rsp_data_d   = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_valid && req_ready) begin
                    dgram_d                                = '0;
                    dgram_d[DGRAM_WRITE_BIT]               = req_write;
                    dgram_d[DGRAM_ADDR_HI:DGRAM_ADDR_LO]   = req_addr;
                    dgram_d[DGRAM_DATA_W-1:0]              = req_write ? req_data : '0;
                    cs_d                                   = req_cs;
                    phase_d                                = 1'b0;
                    state_d                                = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (cnt_q == FRAME_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    // The first read frame only primes the driver; resend the same datagram to fetch the data.
                    if (dgram_q[DGRAM_WRITE_BIT] || phase_q) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        phase_d = 1'b1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_CAPTURE: begin
                cnt_d        = '0;
                rsp_valid_d  = 1'b1;
                rsp_status_d = spi_data_in[DGRAM_WRITE_BIT -: STATUS_W];
                rsp_data_d   = spi_data_in[DGRAM_DATA_W-1:0];
                state_d      = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        en_d = (state_d == ST_SEND);
    end

    always_ff @(posedge internal_clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            dgram_q      <= '0;
            cs_q         <= '0;
            en_q         <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_status_q <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            dgram_q      <= dgram_d;
            cs_q         <= cs_d;
            en_q         <= en_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_status_q <= rsp_status_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_tmc_reg_sequencer.sv
// Self-checking bench: two sequencers (GAP_CYCLES=2/CS_SIZE=2 and GAP_CYCLES=1/CS_SIZE=1)
// exercised with directed and random requests against a cycle-indexed timing model.
module tb_tmc_reg_sequencer;

    localparam int SIZE = 40;
    localparam int F    = SIZE + 3;

    logic        internal_clk = 1'b0;
    logic        reset_n_in;
    logic        valid_a, valid_b;
    logic        req_write;
    logic [6:0]  req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_cs;
    logic [39:0] spi_data_in;

    logic        a_ready, a_rsp_valid, a_en, a_busy;
    logic [7:0]  a_status;
    logic [31:0] a_rdata;
    logic [39:0] a_dout;
    logic [1:0]  a_cs;

    logic        b_ready, b_rsp_valid, b_en, b_busy;
    logic [7:0]  b_status;
    logic [31:0] b_rdata;
    logic [39:0] b_dout;
    logic [0:0]  b_cs;

    logic [39:0] exp_rsp_a, exp_rsp_b;
    int tests_run    = 0;
    int tests_failed = 0;

    always #5 internal_clk = ~internal_clk;

    tmc_reg_sequencer #(.SIZE(SIZE), .CS_SIZE(2), .GAP_CYCLES(2)) dut_a (
        .internal_clk(internal_clk), .reset_n_in(reset_n_in),
        .req_valid(valid_a), .req_ready(a_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data), .req_cs(req_cs),
        .rsp_valid(a_rsp_valid), .rsp_status(a_status), .rsp_data(a_rdata),
        .spi_data_out(a_dout), .spi_send_enable(a_en), .spi_cs_select(a_cs),
        .spi_data_in(spi_data_in), .busy(a_busy)
    );

    tmc_reg_sequencer #(.SIZE(SIZE), .CS_SIZE(1), .GAP_CYCLES(1)) dut_b (
        .internal_clk(internal_clk), .reset_n_in(reset_n_in),
        .req_valid(valid_b), .req_ready(b_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data), .req_cs(req_cs[0]),
        .rsp_valid(b_rsp_valid), .rsp_status(b_status), .rsp_data(b_rdata),
        .spi_data_out(b_dout), .spi_send_enable(b_en), .spi_cs_select(b_cs),
        .spi_data_in(spi_data_in), .busy(b_busy)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [39:0] randWord();
        return {8'($urandom()), 32'($urandom())};
    endfunction

    // One request on DUT 'which' (0 = a, 1 = b), checked cycle by cycle from the acceptance edge.
    // Cycle k is the half-period after edge k-1 past acceptance; frames, gaps and the response
    // position follow from plain arithmetic on frame length, gap length and frame count.
    task automatic applyStimulus(input int which, input bit wr, input logic [6:0] addr,
                                 input logic [31:0] data, input logic [1:0] cs,
                                 input logic [39:0] resp, input bit hold);
        int gap, nfr, lat, rsamp, k_hi, lo;
        logic [39:0] dgram, prev_rsp;
        logic en_exp;
        logic o_ready, o_busy, o_rv, o_en;
        logic [7:0] o_status;
        logic [31:0] o_rdata;
        logic [39:0] o_dout;
        logic [1:0] o_cs;

        gap      = which ? 1 : 2;
        nfr      = wr ? 1 : 2;
        lat      = 2 + nfr * (F + gap);
        rsamp    = lat + 1;
        k_hi     = 1 + (nfr - 1) * (F + gap) + F;
        dgram    = {wr, addr, wr ? data : 32'h0};
        prev_rsp = which ? exp_rsp_b : exp_rsp_a;

        @(negedge internal_clk);
        checkOutput("ready_idle", which ? b_ready : a_ready, 1);
        checkOutput("rsp_hold_status", which ? b_status : a_status, prev_rsp[39:32]);
        checkOutput("rsp_hold_data", which ? b_rdata : a_rdata, prev_rsp[31:0]);
        req_write   = wr;
        req_addr    = addr;
        req_data    = data;
        req_cs      = cs;
        spi_data_in = randWord();
        if (which == 1) valid_b = 1'b1; else valid_a = 1'b1;

        for (int k = 1; k <= rsamp; k++) begin
            @(negedge internal_clk);
            o_ready  = which ? b_ready : a_ready;
            o_busy   = which ? b_busy : a_busy;
            o_rv     = which ? b_rsp_valid : a_rsp_valid;
            o_en     = which ? b_en : a_en;
            o_status = which ? b_status : a_status;
            o_rdata  = which ? b_rdata : a_rdata;
            o_dout   = which ? b_dout : a_dout;
            o_cs     = which ? {1'b0, b_cs} : a_cs;

            en_exp = 1'b0;
            for (int f = 0; f < nfr; f++) begin
                lo = 2 + f * (F + gap);
                if (k >= lo && k < lo + F) en_exp = 1'b1;
            end

            checkOutput("send_enable", o_en, en_exp);
            checkOutput("data_out", o_dout, dgram);
            checkOutput("cs_select", o_cs, cs);
            checkOutput("rsp_valid", o_rv, (k == rsamp));
            checkOutput("ready_busy", o_ready, 0);
            checkOutput("busy", o_busy, 1);
            if (k == rsamp) begin
                checkOutput("rsp_status", o_status, resp[39:32]);
                checkOutput("rsp_data", o_rdata, resp[31:0]);
            end

            // Loopback: the final frame's reply appears once its enable window closes.
            spi_data_in = (k > k_hi && k <= lat) ? resp : randWord();
            if (!hold) begin
                if (k < rsamp) begin
                    req_write = 1'($urandom());
                    req_addr  = 7'($urandom());
                    req_data  = $urandom();
                    req_cs    = 2'($urandom());
                end
                if (which == 1) valid_b = (k < rsamp) ? 1'($urandom()) : 1'b0;
                else            valid_a = (k < rsamp) ? 1'($urandom()) : 1'b0;
            end
        end
        if (which == 1) exp_rsp_b = resp; else exp_rsp_a = resp;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ready_a"}, a_ready, 1);
        checkOutput({tag, "_busy_a"}, a_busy, 0);
        checkOutput({tag, "_rv_a"}, a_rsp_valid, 0);
        checkOutput({tag, "_en_a"}, a_en, 0);
        checkOutput({tag, "_dout_a"}, a_dout, 0);
        checkOutput({tag, "_cs_a"}, a_cs, 0);
        checkOutput({tag, "_status_a"}, a_status, 0);
        checkOutput({tag, "_rdata_a"}, a_rdata, 0);
        checkOutput({tag, "_ready_b"}, b_ready, 1);
        checkOutput({tag, "_en_b"}, b_en, 0);
        checkOutput({tag, "_dout_b"}, b_dout, 0);
    endtask

    initial begin
        logic [39:0] resp;
        reset_n_in  = 1'b0;
        valid_a     = 1'b0;
        valid_b     = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_data    = '0;
        req_cs      = '0;
        spi_data_in = '0;
        exp_rsp_a   = '0;
        exp_rsp_b   = '0;

        repeat (3) @(negedge internal_clk);
        checkIdle("reset");
        reset_n_in = 1'b1;

        applyStimulus(0, 1'b1, 7'h6C, 32'h000100C3, 2'd0, randWord(), 1'b0);
        applyStimulus(0, 1'b0, 7'h6F, 32'hDEADBEEF, 2'd0, 40'h05_0000_1234, 1'b0);

        // Request held high through a write: the follow-up is taken right after the response.
        applyStimulus(0, 1'b1, 7'h10, 32'hCAFE0001, 2'd1, randWord(), 1'b1);
        applyStimulus(0, 1'b1, 7'h11, 32'hCAFE0002, 2'd3, randWord(), 1'b0);

        // Reset in the middle of a SEND frame.
        @(negedge internal_clk);
        req_write = 1'b1;
        req_addr  = 7'h22;
        req_data  = 32'h12345678;
        req_cs    = 2'd1;
        valid_a   = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge internal_clk);
            valid_a = 1'b0;
        end
        checkOutput("pre_reset_en", a_en, 1);
        reset_n_in = 1'b0;
        #1;
        exp_rsp_a = '0;
        exp_rsp_b = '0;
        checkIdle("midreset");
        @(negedge internal_clk);
        reset_n_in = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge internal_clk);
            checkOutput("post_reset_rv", a_rsp_valid, 0);
            checkOutput("post_reset_en", a_en, 0);
        end
        applyStimulus(0, 1'b1, 7'h23, 32'h87654321, 2'd2, randWord(), 1'b0);

        // Single-cycle gap on the second instance, back-to-back reads.
        applyStimulus(1, 1'b0, 7'h01, 32'h0, 2'd1, randWord(), 1'b0);
        applyStimulus(1, 1'b0, 7'h02, 32'h0, 2'd0, randWord(), 1'b0);
        applyStimulus(1, 1'b1, 7'h03, 32'hA5A5A5A5, 2'd1, randWord(), 1'b0);

        // Wide chip-select index held across the inter-frame gap of a read.
        applyStimulus(0, 1'b0, 7'h6F, 32'h0, 2'd2, randWord(), 1'b0);

        for (int i = 0; i < 16; i++) begin
            resp = randWord();
            if ($urandom_range(0, 1) == 1)
                applyStimulus(1, 1'($urandom()), 7'($urandom()), $urandom(), 2'($urandom_range(0, 1)), resp, 1'b0);
            else
                applyStimulus(0, 1'($urandom()), 7'($urandom()), $urandom(), 2'($urandom()), resp, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
